// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg: shared MSHR entry types for the instruction-cache miss path.
// Address, way and counter fields use fixed maximum widths so the struct serves any parameterisation.
package sargantana_icache_pkg;
  localparam int MAX_PADDR_W = 64;
  localparam int MAX_WAY_W = 8;
  localparam int MAX_CNT_W = 8;
  typedef enum logic [1:0] {IDLE, WAIT_ISSUE, WAIT_RESP, FILL} mshr_state_e;
  typedef struct packed {
    mshr_state_e state;
    logic [MAX_PADDR_W-1:0] paddr;
    logic [MAX_WAY_W-1:0] way;
    logic prefetch;
    logic killed;
    logic keep;
    logic [MAX_CNT_W-1:0] cnt;
  } mshr_entry_t;
endpackage

// File: rtl/sargantana_icache_rr_arbiter.sv
// sargantana_icache_rr_arbiter: N-input round-robin arbiter with one-hot grant.
// The pointer parks on an unaccepted grant, so the presented id stays stable until ack.
module sargantana_icache_rr_arbiter #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            ack,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);
  logic [ID_W-1:0] ptr, idx;
  always_comb begin
    grant = '0;
    grant_id = ptr;
    idx = ptr;
    // scanned from farthest to nearest so the requester closest to ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        grant_id = idx;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (|req) ptr <= ack ? grant_id + ID_W'(1) : grant_id;
  end
endmodule

// File: rtl/sargantana_icache_mshr.sv
// sargantana_icache_mshr: miss status holding registers for the instruction cache.
// Tracks outstanding line misses, issues fill requests, gathers beats and emits whole lines.
module sargantana_icache_mshr
  import sargantana_icache_pkg::*;
#(
  parameter int N_ENTRIES = 4,
  parameter int PADDR_W = 40,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 128,
  parameter int WAY_W = 2,
  parameter bit PREFETCH_EN = 1'b0,
  localparam int ID_W = $clog2(N_ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               miss_valid_i,
  output logic               miss_ready_o,
  input  logic [PADDR_W-1:0] miss_paddr_i,
  input  logic [WAY_W-1:0]   miss_way_i,
  input  logic               kill_i,
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output logic [PADDR_W-1:0] req_paddr_o,
  output logic [ID_W-1:0]    req_id_o,
  input  logic               resp_valid_i,
  input  logic [ID_W-1:0]    resp_id_i,
  input  logic [BEAT_W-1:0]  resp_data_i,
  input  logic               inv_valid_i,
  input  logic [PADDR_W-1:0] inv_paddr_i,
  output logic               fill_valid_o,
  output logic [PADDR_W-1:0] fill_paddr_o,
  output logic [WAY_W-1:0]   fill_way_o,
  output logic [LINE_W-1:0]  fill_data_o,
  output logic               fill_keep_o,
  output logic               full_o,
  output logic               busy_o
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int OFF = $clog2(LINE_W / 8);
  mshr_entry_t e [N_ENTRIES];
  logic [BEATS-1:0][BEAT_W-1:0] dbuf [N_ENTRIES];
  logic [N_ENTRIES-1:0] idle, merge_hit, pf_hit, inv_hit, issue_req, grant, dem_oh, pf_oh;
  logic [ID_W-1:0] grant_id, fill_id;
  logic pf_pend, pf_go, fill_any, merge, alloc, miss_fire, req_fire, resp_ok;
  logic [PADDR_W-1:0] pf_addr;
  logic [WAY_W-1:0] pf_way;
  function automatic logic same_line(input logic [MAX_PADDR_W-1:0] a, input logic [PADDR_W-1:0] b);
    return (a >> OFF) == (MAX_PADDR_W'(b) >> OFF);
  endfunction
  always_comb begin
    idle = '0;
    merge_hit = '0;
    pf_hit = '0;
    inv_hit = '0;
    issue_req = '0;
    fill_any = 1'b0;
    fill_id = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      idle[i] = e[i].state == IDLE;
      issue_req[i] = e[i].state == WAIT_ISSUE;
      merge_hit[i] = !idle[i] && !e[i].killed && same_line(e[i].paddr, miss_paddr_i);
      pf_hit[i] = !idle[i] && same_line(e[i].paddr, pf_addr);
      inv_hit[i] = inv_valid_i && !idle[i] && same_line(e[i].paddr, inv_paddr_i);
      if (e[i].state == FILL) begin
        fill_any = 1'b1;
        fill_id = ID_W'(i);
      end
    end
  end
  assign merge = |merge_hit;
  assign miss_ready_o = !kill_i && (|idle || merge);
  assign miss_fire = miss_valid_i && miss_ready_o;
  assign alloc = miss_fire && !merge;
  // a demand allocation of the same line this cycle already covers the prefetch
  assign pf_go = pf_pend && !(|pf_hit) && !(alloc && same_line(MAX_PADDR_W'(miss_paddr_i), pf_addr));
  always_comb begin
    dem_oh = '0;
    pf_oh = '0;
    for (int i = 0; i < N_ENTRIES; i++)
      if (alloc && idle[i] && dem_oh == '0) dem_oh[i] = 1'b1;
    for (int i = 0; i < N_ENTRIES; i++)
      if (pf_go && idle[i] && !dem_oh[i] && pf_oh == '0) pf_oh[i] = 1'b1;
  end
  sargantana_icache_rr_arbiter #(.N(N_ENTRIES)) u_arb (
    .clk(clk_i), .rst(rst_i), .req(issue_req), .ack(req_ready_i), .grant(grant), .grant_id(grant_id)
  );
  assign req_valid_o = |issue_req;
  assign req_fire = req_valid_o && req_ready_i;
  assign req_id_o = grant_id;
  assign req_paddr_o = PADDR_W'(e[grant_id].paddr);
  assign resp_ok = resp_valid_i && e[resp_id_i].state == WAIT_RESP;
  assign fill_valid_o = fill_any && !e[fill_id].killed;
  assign fill_keep_o = fill_valid_o && e[fill_id].keep && !inv_hit[fill_id];
  assign fill_paddr_o = PADDR_W'(e[fill_id].paddr);
  assign fill_way_o = WAY_W'(e[fill_id].way);
  assign fill_data_o = dbuf[fill_id];
  assign full_o = ~|idle;
  assign busy_o = ~&idle;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) e[i] <= '0;
      pf_pend <= 1'b0;
      pf_addr <= '0;
      pf_way <= '0;
    end else begin
      pf_pend <= PREFETCH_EN && alloc;
      if (alloc) begin
        pf_addr <= miss_paddr_i + PADDR_W'(LINE_W / 8);
        pf_way <= miss_way_i;
      end
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (inv_hit[i]) e[i].keep <= 1'b0;
        if (miss_fire && merge_hit[i]) e[i].prefetch <= 1'b0;
        case (e[i].state)
          IDLE: if (dem_oh[i] || pf_oh[i])
            e[i] <= '{state: WAIT_ISSUE, paddr: MAX_PADDR_W'(dem_oh[i] ? miss_paddr_i : pf_addr),
                      way: MAX_WAY_W'(dem_oh[i] ? miss_way_i : pf_way), prefetch: pf_oh[i],
                      killed: 1'b0, keep: 1'b1, cnt: '0};
          // an accepted request must collect its beats even if killed, so the id is not reused early
          WAIT_ISSUE: if (req_fire && grant[i]) begin
            e[i].state <= WAIT_RESP;
            e[i].killed <= kill_i && !e[i].prefetch;
          end else if (kill_i && !e[i].prefetch) e[i].state <= IDLE;
          WAIT_RESP: begin
            if (kill_i && !e[i].prefetch) e[i].killed <= 1'b1;
            if (resp_ok && resp_id_i == ID_W'(i)) begin
              e[i].state <= e[i].cnt == MAX_CNT_W'(BEATS - 1) ? FILL : WAIT_RESP;
              e[i].cnt <= e[i].cnt == MAX_CNT_W'(BEATS - 1) ? '0 : e[i].cnt + MAX_CNT_W'(1);
            end
          end
          default: e[i].state <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk_i)
    if (resp_ok) dbuf[resp_id_i][CNT_W'(e[resp_id_i].cnt)] <= resp_data_i;
endmodule

// File: tb/tb_sargantana_icache_mshr.sv
// tb_sargantana_icache_mshr: directed bench with a behavioural MSHR model checked every cycle.
module tb_sargantana_icache_mshr;
  logic clk = 0, rst = 0;
  logic miss_valid = 0, kill = 0, req_ready = 0, resp_valid = 0, inv_valid = 0;
  logic [39:0] miss_paddr = '0, inv_paddr = '0;
  logic [1:0] miss_way = '0, resp_id = '0;
  logic [127:0] resp_data = '0;
  logic miss_ready, req_valid, fill_valid, fill_keep, full, busy;
  logic [39:0] req_paddr, fill_paddr;
  logic [1:0] req_id, fill_way;
  logic [255:0] fill_data;
  logic p_miss_valid = 0, p_req_ready = 0, p_resp_valid = 0, p_zero = 0;
  logic [39:0] p_miss_paddr = '0, p_zaddr = '0;
  logic [1:0] p_miss_way = '0, p_resp_id = '0;
  logic [127:0] p_resp_data = '0;
  logic p_miss_ready, p_req_valid, p_fill_valid, p_fill_keep, p_full, p_busy;
  logic [39:0] p_req_paddr, p_fill_paddr;
  logic [1:0] p_req_id, p_fill_way;
  logic [255:0] p_fill_data;
  int errors = 0, checks = 0;
  logic [127:0] A = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  logic [127:0] B = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
  int ids[8] = '{2, 0, 2, 0, 3, 3, 1, 1};
  always #5 clk = ~clk;
  sargantana_icache_mshr dut (
    .clk_i(clk), .rst_i(rst), .miss_valid_i(miss_valid), .miss_ready_o(miss_ready),
    .miss_paddr_i(miss_paddr), .miss_way_i(miss_way), .kill_i(kill), .req_valid_o(req_valid),
    .req_ready_i(req_ready), .req_paddr_o(req_paddr), .req_id_o(req_id), .resp_valid_i(resp_valid),
    .resp_id_i(resp_id), .resp_data_i(resp_data), .inv_valid_i(inv_valid), .inv_paddr_i(inv_paddr),
    .fill_valid_o(fill_valid), .fill_paddr_o(fill_paddr), .fill_way_o(fill_way), .fill_data_o(fill_data),
    .fill_keep_o(fill_keep), .full_o(full), .busy_o(busy)
  );
  sargantana_icache_mshr #(.PREFETCH_EN(1'b1)) dut_pf (
    .clk_i(clk), .rst_i(rst), .miss_valid_i(p_miss_valid), .miss_ready_o(p_miss_ready),
    .miss_paddr_i(p_miss_paddr), .miss_way_i(p_miss_way), .kill_i(p_zero), .req_valid_o(p_req_valid),
    .req_ready_i(p_req_ready), .req_paddr_o(p_req_paddr), .req_id_o(p_req_id), .resp_valid_i(p_resp_valid),
    .resp_id_i(p_resp_id), .resp_data_i(p_resp_data), .inv_valid_i(p_zero), .inv_paddr_i(p_zaddr),
    .fill_valid_o(p_fill_valid), .fill_paddr_o(p_fill_paddr), .fill_way_o(p_fill_way), .fill_data_o(p_fill_data),
    .fill_keep_o(p_fill_keep), .full_o(p_full), .busy_o(p_busy)
  );
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic miss(input logic [39:0] a, input logic [1:0] w);
    miss_valid = 1;
    miss_paddr = a;
    miss_way = w;
  endtask
  task automatic beat(input int id, input logic [127:0] d);
    resp_valid = 1;
    resp_id = 2'(id);
    resp_data = d;
  endtask
  // model: state 0 idle, 1 waiting issue, 2 waiting beats, 3 filling
  int st[4], nb[4], rr = 0, hid = 0;
  bit hold = 0, kp[4], kl[4];
  logic [39:0] ad[4];
  logic [1:0] wy[4];
  logic [127:0] bt[4][2];
  bit e_ready, e_rv, e_fv, e_fk, e_full, e_busy, e_merge;
  int e_rid, e_fid;
  task automatic calc();
    int free = 0;
    e_merge = 0; e_fv = 0; e_fk = 0; e_fid = 0; e_rv = 0; e_rid = 0;
    for (int i = 0; i < 4; i++) begin
      if (st[i] == 0) free++;
      else if (!kl[i] && ad[i][39:5] == miss_paddr[39:5]) e_merge = 1;
      if (st[i] == 3) begin
        e_fid = i;
        e_fv = !kl[i];
        e_fk = !kl[i] && kp[i] && !(inv_valid && inv_paddr[39:5] == ad[i][39:5]);
      end
    end
    e_ready = !kill && (free > 0 || e_merge);
    e_full = free == 0;
    e_busy = free < 4;
    if (hold && st[hid] == 1) begin
      e_rv = 1;
      e_rid = hid;
    end else
      for (int k = 0; k < 4; k++)
        if (!e_rv && st[(rr + k) % 4] == 1) begin
          e_rv = 1;
          e_rid = (rr + k) % 4;
        end
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin st[i] = 0; nb[i] = 0; kl[i] = 0; kp[i] = 0; end
      rr = 0;
      hold = 0;
    end else begin
      int os[4];
      bit done;
      calc();
      os = st;
      for (int i = 0; i < 4; i++) begin
        if (os[i] != 0 && inv_valid && inv_paddr[39:5] == ad[i][39:5]) kp[i] = 0;
        if (os[i] == 3) st[i] = 0;
        if (os[i] == 1 && kill && !(e_rv && req_ready && e_rid == i)) st[i] = 0;
        if (os[i] == 2 && kill) kl[i] = 1;
      end
      if (e_rv && req_ready) begin
        st[e_rid] = 2;
        kl[e_rid] = kill;
        hold = 0;
        rr = (e_rid + 1) % 4;
      end else if (e_rv) begin
        hold = 1;
        hid = e_rid;
      end
      if (resp_valid && os[resp_id] == 2) begin
        bt[resp_id][nb[resp_id]] = resp_data;
        nb[resp_id]++;
        if (nb[resp_id] == 2) begin st[resp_id] = 3; nb[resp_id] = 0; end
      end
      done = 0;
      if (miss_valid && e_ready && !e_merge)
        for (int i = 0; i < 4; i++)
          if (!done && os[i] == 0) begin
            done = 1;
            st[i] = 1; ad[i] = miss_paddr; wy[i] = miss_way; kp[i] = 1; kl[i] = 0; nb[i] = 0;
          end
    end
  end
  always @(negedge clk) begin
    calc();
    chk("miss_ready", miss_ready, e_ready);
    chk("req_valid", req_valid, e_rv);
    if (e_rv) begin
      chk("req_id", req_id, e_rid);
      chk("req_paddr", req_paddr, ad[e_rid]);
    end
    chk("fill_valid", fill_valid, e_fv);
    chk("fill_keep", fill_keep, e_fk);
    if (e_fv) begin
      chk("fill_paddr", fill_paddr, ad[e_fid]);
      chk("fill_way", fill_way, wy[e_fid]);
      chk("fill_data", fill_data, {bt[e_fid][1], bt[e_fid][0]});
    end
    chk("full", full, e_full);
    chk("busy", busy, e_busy);
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
  initial begin
    #1 rst = 1;
    #2;
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_keep", fill_keep, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    nxt(); nxt(); rst = 0;
    req_ready = 1;
    miss(40'h1000, 2);
    #2 chk("a_accept", miss_ready, 1);
    nxt(); miss_valid = 0;
    #2 chk("a_req_valid", req_valid, 1);
    chk("a_req_id", req_id, 0);
    chk("a_req_paddr", req_paddr, 40'h1000);
    nxt(); beat(0, A);
    nxt(); beat(0, B);
    nxt(); resp_valid = 0;
    #2 chk("a_fill_valid", fill_valid, 1);
    chk("a_fill_data", fill_data, {B, A});
    chk("a_fill_way", fill_way, 2);
    chk("a_fill_keep", fill_keep, 1);
    nxt();
    #2 chk("a_idle", busy, 0);
    miss(40'h1000, 1);
    nxt(); miss_valid = 0;
    nxt(); beat(0, B);
    nxt(); resp_valid = 0; inv_valid = 1; inv_paddr = 40'h1000;
    nxt(); inv_valid = 0; beat(0, A);
    nxt(); resp_valid = 0;
    #2 chk("inv_fill_valid", fill_valid, 1);
    chk("inv_fill_keep", fill_keep, 0);
    nxt(); miss(40'h3000, 0);
    nxt(); miss_valid = 0;
    nxt(); kill = 1;
    #2 chk("kill_miss_ready", miss_ready, 0);
    nxt(); kill = 0; beat(0, A);
    nxt(); beat(0, B);
    nxt(); resp_valid = 0;
    #2 chk("kill_no_fill", fill_valid, 0);
    nxt();
    #2 chk("kill_idle", busy, 0);
    req_ready = 0; miss(40'h6000, 3);
    nxt(); miss_valid = 0; kill = 1;
    nxt(); kill = 0;
    #2 chk("kill_issue_idle", busy, 0);
    chk("kill_issue_noreq", req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      miss(40'(32'h1000 * (i + 1)), 2'(i));
      nxt();
    end
    #2 chk("full_after_4", full, 1);
    miss(40'h5000, 0);
    #1 chk("full_stall", miss_ready, 0);
    miss(40'h1000, 0);
    #1 chk("full_merge", miss_ready, 1);
    chk("full_req_id", req_id, 0);
    chk("full_req_paddr", req_paddr, 40'h1000);
    nxt(); miss_valid = 0; req_ready = 1;
    nxt(); nxt(); nxt(); nxt(); req_ready = 0;
    #2 chk("all_issued", req_valid, 0);
    for (int k = 0; k < 8; k++) begin
      beat(ids[k], {4{32'(k + 1)}});
      nxt();
    end
    beat(1, A);
    nxt(); resp_valid = 0;
    nxt();
    #2 chk("drain_idle", busy, 0);
    req_ready = 1; miss(40'h7000, 2);
    nxt(); miss_valid = 0;
    nxt(); beat(0, A);
    nxt(); resp_valid = 0; rst = 1;
    #1 chk("rr_busy", busy, 0);
    chk("rr_req_valid", req_valid, 0);
    chk("rr_fill_valid", fill_valid, 0);
    chk("rr_fill_keep", fill_keep, 0);
    chk("rr_full", full, 0);
    chk("rr_miss_ready", miss_ready, 1);
    nxt(); rst = 0; beat(0, B);
    nxt(); resp_valid = 0;
    #2 chk("stray_no_fill", fill_valid, 0);
    chk("stray_idle", busy, 0);
    p_req_ready = 1; p_miss_valid = 1; p_miss_paddr = 40'h2000; p_miss_way = 1;
    nxt(); p_miss_valid = 0;
    #2 chk("pf_req0_id", p_req_id, 0);
    chk("pf_req0_paddr", p_req_paddr, 40'h2000);
    nxt();
    #2 chk("pf_req1_valid", p_req_valid, 1);
    chk("pf_req1_id", p_req_id, 1);
    chk("pf_req1_paddr", p_req_paddr, 40'h2020);
    nxt();
    #2 chk("pf_no_req", p_req_valid, 0);
    p_miss_valid = 1; p_miss_paddr = 40'h2020; p_miss_way = 3;
    #1 chk("pf_merge_ready", p_miss_ready, 1);
    nxt(); p_miss_valid = 0;
    #2 chk("pf_no_third", p_req_valid, 0);
    chk("pf_busy", p_busy, 1);
    p_resp_valid = 1; p_resp_id = 1; p_resp_data = A;
    nxt(); p_resp_data = B;
    nxt(); p_resp_valid = 0;
    #2 chk("pf_fill_valid", p_fill_valid, 1);
    chk("pf_fill_paddr", p_fill_paddr, 40'h2020);
    chk("pf_fill_way", p_fill_way, 1);
    chk("pf_fill_data", p_fill_data, {B, A});
    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
